// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one async SRAM between VGA scan-out fetches and a host port.
// Display requests take strict priority; the host gets the leftover access slots.
module vram_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              disp_overrun,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);
  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DRD, HRD, HWR} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic disp_pend;
  logic [ADDR_W-1:0] disp_lat;
  logic disp_start, host_start;
  assign disp_start = (state == IDLE) && (disp_pend || disp_req);
  assign host_ready = (state == IDLE) && !disp_pend && !disp_req;
  assign host_start = host_ready && host_valid;
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      disp_pend <= 1'b0;
      disp_lat <= '0;
      disp_overrun <= 1'b0;
      disp_valid <= 1'b0;
      host_rvalid <= 1'b0;
      disp_data <= '0;
      host_rdata <= '0;
      sram_addr <= '0;
      sram_dq_o <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
    end else begin
      disp_valid <= 1'b0;
      host_rvalid <= 1'b0;
      if (disp_start) disp_pend <= 1'b0;
      else if (disp_req) begin
        disp_pend <= 1'b1;
        disp_lat <= disp_addr;
        if (disp_pend) disp_overrun <= 1'b1;
      end
      if (disp_start) begin
        state <= DRD;
        cnt <= LAST;
        sram_addr <= disp_req ? disp_addr : disp_lat;
        sram_ce_n <= 1'b0;
        sram_oe_n <= 1'b0;
      end else if (host_start) begin
        state <= host_we ? HWR : HRD;
        cnt <= LAST;
        sram_addr <= host_addr;
        sram_dq_o <= host_wdata;
        sram_dq_oe <= host_we;
        sram_ce_n <= 1'b0;
        sram_oe_n <= host_we;
        sram_we_n <= !host_we;
      end else if (state != IDLE) begin
        if (cnt == '0) begin
          state <= IDLE;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_dq_oe <= 1'b0;
          disp_valid <= state == DRD;
          host_rvalid <= state == HRD;
          if (state == DRD) disp_data <= sram_dq_i;
          if (state == HRD) host_rdata <= sram_dq_i;
        end else begin
          cnt <= cnt - CW'(1);
          // release we_n one cycle early so data/address hold past the strobe
          if (cnt == CW'(1)) sram_we_n <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed table, corner sequences and a randomized run
// checked against a transaction-level model of the arbiter.
module tb_vram_arbiter;
  localparam int ACC = 2;
  logic clk100 = 1'b0;
  logic rst_n;
  logic disp_req, host_valid, host_we, host_ready;
  logic [17:0] disp_addr, host_addr, sram_addr;
  logic [15:0] disp_data, host_wdata, host_rdata, sram_dq_o, sram_dq_i;
  logic disp_valid, disp_overrun, host_rvalid, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  int tests = 0, fails = 0;
  logic [15:0] sram_mem [0:262143];
  vram_arbiter #(.ADDR_W(18), .DATA_W(16), .ACCESS_CYCLES(ACC)) dut (
    .clk100(clk100), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid), .disp_overrun(disp_overrun),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );
  always #5 clk100 = ~clk100;
  // async SRAM: read data settles well before the next rising edge
  always @(negedge clk100) sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0;
  always @(posedge clk100) if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq_o;
  function automatic logic [15:0] pat(input logic [17:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk100);
    #1;
  endtask
  task automatic wait_disp(output int lat);
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      tick;
      disp_req = 1'b0;
      host_valid = 1'b0;
      if (disp_valid) begin
        lat = n;
        break;
      end
    end
  endtask
  task automatic wait_host(output int lat);
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      tick;
      disp_req = 1'b0;
      host_valid = 1'b0;
      if (host_rvalid) begin
        lat = n;
        break;
      end
    end
  endtask
  typedef struct {int kind; logic [17:0] addr; logic [15:0] wdata; logic [15:0] exp;} vec_t;
  vec_t vt [10];
  logic [15:0] ref_mem [0:63];
  initial begin
    int lat, pulses, m_busy, dv_c, hv_c;
    bit m_pend, m_ovr, exp_rdy;
    logic [5:0] m_paddr, a;
    logic [15:0] dd, hd;
    vt[0] = '{1, 18'h00020, 16'h1234, 16'h1234};
    vt[1] = '{2, 18'h00020, 16'h0000, 16'h1234};
    vt[2] = '{0, 18'h00020, 16'h0000, 16'h1234};
    vt[3] = '{1, 18'h3FFFF, 16'hFFFF, 16'hFFFF};
    vt[4] = '{2, 18'h3FFFF, 16'h0000, 16'hFFFF};
    vt[5] = '{0, 18'h3FFFF, 16'h0000, 16'hFFFF};
    vt[6] = '{1, 18'h00000, 16'h0000, 16'h0000};
    vt[7] = '{0, 18'h00000, 16'h0000, 16'h0000};
    vt[8] = '{2, 18'h00021, 16'h0000, 16'h5A1D};
    vt[9] = '{0, 18'h257FF, 16'h0000, 16'h0DC3};
    rst_n = 1'b1;
    {disp_req, host_valid, host_we} = '0;
    disp_addr = '0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 262144; i++) sram_mem[i] = pat(18'(i));
    sram_mem[18'h00100] = 16'hA55A;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ce_n", sram_ce_n, 1); chk("rst_oe_n", sram_oe_n, 1); chk("rst_we_n", sram_we_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0); chk("rst_addr", sram_addr, 0); chk("rst_dvalid", disp_valid, 0);
    chk("rst_rvalid", host_rvalid, 0); chk("rst_overrun", disp_overrun, 0);
    chk("rst_ddata", disp_data, 0); chk("rst_hdata", host_rdata, 0);
    tick; tick;
    rst_n = 1'b1;
    // display fetch from idle
    tick;
    disp_req = 1'b1; disp_addr = 18'h00100;
    #1 chk("t1_ready_blocked", host_ready, 0);
    tick; disp_req = 1'b0;
    chk("t1_ce_n_1", sram_ce_n, 0); chk("t1_oe_n_1", sram_oe_n, 0); chk("t1_addr", sram_addr, 18'h00100);
    chk("t1_dvalid_1", disp_valid, 0);
    tick;
    chk("t1_ce_n_2", sram_ce_n, 0); chk("t1_oe_n_2", sram_oe_n, 0); chk("t1_dvalid_2", disp_valid, 0);
    tick;
    chk("t1_dvalid_3", disp_valid, 1); chk("t1_ddata", disp_data, 16'hA55A); chk("t1_ce_n_3", sram_ce_n, 1);
    tick;
    chk("t1_dvalid_4", disp_valid, 0);
    // host write
    host_valid = 1'b1; host_we = 1'b1; host_addr = 18'h12345; host_wdata = 16'hBEEF;
    #1 chk("t2_ready", host_ready, 1);
    tick; host_valid = 1'b0;
    chk("t2_we_n_1", sram_we_n, 0); chk("t2_dq_oe_1", sram_dq_oe, 1); chk("t2_dq_o", sram_dq_o, 16'hBEEF);
    chk("t2_ce_n_1", sram_ce_n, 0); chk("t2_oe_n_1", sram_oe_n, 1);
    tick;
    chk("t2_we_n_2", sram_we_n, 1); chk("t2_dq_oe_2", sram_dq_oe, 1); chk("t2_ce_n_2", sram_ce_n, 0);
    tick;
    chk("t2_dq_oe_3", sram_dq_oe, 0); chk("t2_rvalid", host_rvalid, 0); chk("t2_mem", sram_mem[18'h12345], 16'hBEEF);
    // simultaneous display and host read
    disp_req = 1'b1; disp_addr = 18'h00200;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 18'h12345;
    #1 chk("t3_ready_0", host_ready, 0);
    tick; disp_req = 1'b0;
    chk("t3_ready_1", host_ready, 0); chk("t3_addr", sram_addr, 18'h00200);
    tick;
    tick;
    chk("t3_dvalid", disp_valid, 1); chk("t3_ddata", disp_data, pat(18'h00200)); chk("t3_ready_acc", host_ready, 1);
    wait_host(lat);
    chk("t3_rlat", lat, 3); chk("t3_rdata", host_rdata, 16'hBEEF);
    tick;
    // table of transactions issued from idle
    foreach (vt[i]) begin
      if (vt[i].kind == 0) begin
        disp_req = 1'b1; disp_addr = vt[i].addr;
        wait_disp(lat);
        chk("tbl_dlat", lat, 3); chk("tbl_ddata", disp_data, vt[i].exp);
      end else begin
        host_valid = 1'b1; host_we = vt[i].kind == 1; host_addr = vt[i].addr; host_wdata = vt[i].wdata;
        #1 chk("tbl_ready", host_ready, 1);
        if (vt[i].kind == 2) begin
          wait_host(lat);
          chk("tbl_rlat", lat, 3); chk("tbl_rdata", host_rdata, vt[i].exp);
        end else begin
          pulses = 0;
          for (int n = 0; n < 4; n++) begin
            tick; host_valid = 1'b0; pulses += int'(host_rvalid);
          end
          chk("tbl_wr_norvalid", pulses, 0); chk("tbl_wr_mem", sram_mem[vt[i].addr], vt[i].exp);
        end
      end
      tick;
    end
    // display request one cycle after a host write starts
    host_valid = 1'b1; host_we = 1'b1; host_addr = 18'h00040; host_wdata = 16'h1111;
    tick; host_valid = 1'b0;
    disp_req = 1'b1; disp_addr = 18'h00041;
    wait_disp(lat);
    chk("t4_lat", lat, 5); chk("t4_ddata", disp_data, pat(18'h00041)); chk("t4_overrun", disp_overrun, 0);
    tick; tick;
    // two requests while busy: newer address wins, overrun sticks
    host_valid = 1'b1; host_we = 1'b1; host_addr = 18'h00042; host_wdata = 16'h2222;
    tick; host_valid = 1'b0;
    disp_req = 1'b1; disp_addr = 18'h00010;
    tick;
    disp_addr = 18'h00011;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      tick; disp_req = 1'b0;
      if (!sram_ce_n && !sram_oe_n) chk("t5_addr", sram_addr, 18'h00011);
      if (disp_valid) begin
        pulses++;
        chk("t5_ddata", disp_data, pat(18'h00011));
      end
    end
    chk("t5_pulses", pulses, 1); chk("t5_overrun", disp_overrun, 1);
    tick; tick;
    chk("t5_overrun_sticky", disp_overrun, 1);
    // reset in the middle of a write
    host_valid = 1'b1; host_we = 1'b1; host_addr = 18'h00030; host_wdata = 16'h7777;
    tick; host_valid = 1'b0;
    chk("t6_we_n_pre", sram_we_n, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_ce_n", sram_ce_n, 1); chk("t6_we_n", sram_we_n, 1); chk("t6_oe_n", sram_oe_n, 1);
    chk("t6_dq_oe", sram_dq_oe, 0); chk("t6_overrun", disp_overrun, 0);
    tick; tick;
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      tick; pulses += int'(disp_valid) + int'(host_rvalid);
    end
    chk("t6_no_pulse", pulses, 0);
    disp_req = 1'b1; disp_addr = 18'h00030;
    wait_disp(lat);
    chk("t6_dlat", lat, 3); chk("t6_ddata", disp_data, 16'h5A0C);
    tick; tick;
    // randomized traffic against the transaction model
    for (int i = 0; i < 64; i++) ref_mem[i] = sram_mem[i];
    m_busy = 0; m_pend = 0; m_ovr = 0; m_paddr = '0; dv_c = -1; hv_c = -1; dd = '0; hd = '0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      disp_req = $urandom_range(0, 6) == 0;
      disp_addr = 18'($urandom_range(0, 63));
      host_valid = 1'($urandom_range(0, 1));
      host_we = 1'($urandom_range(0, 1));
      host_addr = 18'($urandom_range(0, 63));
      host_wdata = 16'($urandom);
      #1;
      exp_rdy = m_busy == 0 && !m_pend && !disp_req;
      chk("rnd_ready", host_ready, exp_rdy);
      chk("rnd_dvalid", disp_valid, c == dv_c);
      if (c == dv_c) chk("rnd_ddata", disp_data, dd);
      chk("rnd_rvalid", host_rvalid, c == hv_c);
      if (c == hv_c) chk("rnd_rdata", host_rdata, hd);
      chk("rnd_overrun", disp_overrun, m_ovr);
      if (m_busy == 0 && (m_pend || disp_req)) begin
        a = disp_req ? disp_addr[5:0] : m_paddr;
        dd = ref_mem[a]; dv_c = c + ACC + 1; m_busy = ACC; m_pend = 0;
      end else begin
        if (exp_rdy && host_valid) begin
          m_busy = ACC;
          if (host_we) ref_mem[host_addr[5:0]] = host_wdata;
          else begin
            hd = ref_mem[host_addr[5:0]]; hv_c = c + ACC + 1;
          end
        end else if (m_busy > 0) m_busy--;
        if (disp_req) begin
          if (m_pend) m_ovr = 1;
          m_pend = 1; m_paddr = disp_addr[5:0];
        end
      end
    end
    disp_req = 1'b0; host_valid = 1'b0;
    tick; tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
